decode_branch_ctrl: RTL and testbench
=====================================

Name: decode_branch_ctrl

Overview:
- Decode-side partner of the fetch stage. It consumes the fetched instruction and PC, holds the IF/ID pipeline register, and resolves branches and jumps in decode.
- It drives PCSrcD, PCbranchD and hazardDetected back to fetch.
- A two-entry shadow of issued instructions tracks in-flight destination registers for load-use and branch-operand stalls.
- Sits between the fetch stage and the register file / EX stage.

Parameters:
- NOP_INSTR, 32'h0000_0000, bubble/flush encoding loaded into IF/ID.
- RESET_PC, 32'h0000_0000, pcD value after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- instrF  input  32  instruction fetched at pcF.
- pcF  input  32  PC driven by fetch.
- rsDataD  input  32  register file read of rsD (combinational).
- rtDataD  input  32  register file read of rtD (combinational).
- instrD  output  32  IF/ID instruction.
- pcD  output  32  IF/ID PC.
- validD  output  1  instrD is a real instruction (not bubble).
- rsD  output  5  instrD[25:21].
- rtD  output  5  instrD[20:16].
- PCSrcD  output  1  1 = fetch takes PCbranchD.
- PCbranchD  output  32  redirect target.
- hazardDetected  output  1  1 = fetch holds PC; IF/ID holds.
- issueD  output  1  validD && !hazardDetected; instruction leaves decode this cycle.

Behaviour:
- Reset: instrD=NOP_INSTR, pcD=RESET_PC, validD=0, both shadow entries invalid. Consequently PCSrcD=0, PCbranchD=0, hazardDetected=0, issueD=0.
- Decode (combinational from instrD):
  - beq op=000100; bne op=000101; j op=000010; lw op=100011.
  - ALU-I ops 001xxx write rt.
  - R-type op=000000 with instr≠0 writes rd=[15:11].
  - Destination register 0 never counts as a write.
- Branch target = pcD+4 + (sign-extended imm16 <<2), 32-bit wrap-around.
- Jump target = {pcD+4[31:28], instr[25:0], 2'b00}.
- Shadow: EX entry {v, dst, isLoad} and MEM entry {v, dst, isLoad}.
  - Each posedge: MEM<=EX.
  - EX<=decoded instrD if issueD, else invalid (bubble).
- hazardDetected (validD required):
  - (a) Load-use: instrD reads rs (or rt for R-type, beq, bne) equal to EX.dst with EX.isLoad.
  - (b) Branch operand: beq/bne source equals EX.dst for any writer, or equals MEM.dst with MEM.isLoad.
  - j never stalls.
- PCSrcD = validD && !hazardDetected && (j || (beq && rsData==rtData) || (bne && rsData!=rtData)). Stall always wins over redirect.
- PCbranchD = target whenever instrD is beq/bne/j; otherwise 0.
- IF/ID update, in priority order:
  - rst;
  - hazardDetected: hold;
  - PCSrcD (without DELAY_SLOT_EN): load NOP_INSTR, validD=0 (flush the wrong-path instruction);
  - else load instrF/pcF, validD=1.
- Latency: redirect visible to fetch in the same cycle the branch is in decode; one wrong-path slot is flushed.
- Reset mid-stall or mid-redirect: all state cleared next edge; no redirect emitted in the reset cycle.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: a taken branch/jump does not flush IF/ID. The instruction after the branch loads normally (MIPS delay-slot semantics). The branch target is pcD+4-relative as above.
- Undefined: flush behaviour as specified.

Decomposition:
- Package decode_pkg: opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_LW, OP_ALUI prefix), NOP_INSTR default, and the shadow-entry struct {v, dst[4:0], isLoad}.
- One sub-module, instr_dest_decode: combinational, instr -> {writes, dst, isLoad, readsRs, readsRt}. Used for both hazard checks and shadow loading.

Test Plan:
- Reset sequencing: rst=1 for 2 cycles with instrF=32'h8C010004 -> validD=0, hazardDetected=0, PCSrcD=0. First edge after release -> instrD=32'h8C010004, validD=1.
- Load-use stall:
  - Stimulus: lw $1,4($0) followed by add $2,$1,$1 (32'h00211020).
  - Response: hazardDetected=1 for exactly 1 cycle; instrD holds 32'h00211020; EX shadow gets a bubble; issueD=0 that cycle.
- Taken beq:
  - Stimulus: pcD=32'h40, beq $3,$4,+3 with rsDataD=rtDataD=7.
  - Response: PCSrcD=1, PCbranchD=32'h50; next edge instrD=NOP_INSTR, validD=0 (instrD is the following instruction with DELAY_SLOT_EN).
- Not-taken bne: rsDataD=rtDataD=5 -> PCSrcD=0; the next instruction loads normally.
- Branch after load:
  - Stimulus: lw $5 then beq $5,$0.
  - Response: hazardDetected=1 for 2 cycles. PCSrcD=0 during both cycles even when rsDataD==rtDataD; resolves on cycle 3.
- Jump with wrap:
  - Stimulus: pcD=32'hFFFF_FFFC, j 0x0000010.
  - Response: PCbranchD=32'h0000_0040 (pc+4 wraps to 0), PCSrcD=1, no stall.

Source files
------------

// File: rtl/decode_branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/branch control slice.
//   - MIPS opcode constants used by the decoder
//   - default bubble encoding and reset PC
//   - shadow-entry struct tracking one in-flight destination register
//   - decoded destination/source info struct
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_LW       = 6'b100011;
    // ALU-immediate group is every opcode 001xxx
    localparam logic [2:0] OP_ALUI_PFX = 3'b001;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    // One in-flight instruction as seen from decode: valid only when it
    // actually writes a non-zero register.
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       isLoad;
    } shadow_t;

    typedef struct packed {
        logic       writes;
        logic [4:0] dst;
        logic       isLoad;
        logic       readsRs;
        logic       readsRt;
    } dest_info_t;

endpackage

// File: rtl/decode_branch_ctrl_instr_dest_decode.sv
// ---------------------------------------------------------------------------
// instr_dest_decode
// Combinational decode of one instruction word into the register-usage
// summary needed for hazard detection and shadow loading.
// Ports:
//   instr  in  32  instruction word
//   info   out     {writes, dst, isLoad, readsRs, readsRt}
// Register 0 as destination is reported as no write.
// ---------------------------------------------------------------------------
module instr_dest_decode
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output dest_info_t  info
);

    logic [5:0] op;
    logic       raw_writes;
    logic [4:0] raw_dst;

    assign op = instr[31:26];

    always_comb begin
        raw_writes   = 1'b0;
        raw_dst      = 5'd0;
        info.isLoad  = 1'b0;
        info.readsRs = 1'b0;
        info.readsRt = 1'b0;
        if (op == OP_LW) begin
            raw_writes   = 1'b1;
            raw_dst      = instr[20:16];
            info.isLoad  = 1'b1;
            info.readsRs = 1'b1;
        end else if (op[5:3] == OP_ALUI_PFX) begin
            raw_writes   = 1'b1;
            raw_dst      = instr[20:16];
            info.readsRs = 1'b1;
        end else if (op == OP_RTYPE && instr != 32'd0) begin
            raw_writes   = 1'b1;
            raw_dst      = instr[15:11];
            info.readsRs = 1'b1;
            info.readsRt = 1'b1;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            info.readsRs = 1'b1;
            info.readsRt = 1'b1;
        end
    end

    assign info.writes = raw_writes && (raw_dst != 5'd0);
    assign info.dst    = raw_dst;

endmodule

// File: rtl/decode_branch_ctrl.sv
// ---------------------------------------------------------------------------
// decode_branch_ctrl
// Decode stage: IF/ID register, branch/jump resolution in decode, and a
// two-entry (EX, MEM) shadow of issued instructions for stall detection.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instrF, pcF              fetched instruction and its PC
//   rsDataD, rtDataD         register file reads of rsD / rtD
//   instrD, pcD, validD      IF/ID contents
//   rsD, rtD                 source register fields of instrD
//   PCSrcD, PCbranchD        redirect request and target to fetch
//   hazardDetected           stall fetch and IF/ID
//   issueD                   instrD leaves decode this cycle
// Build option: DELAY_SLOT_EN -- when defined, taken branches/jumps do not
// flush IF/ID (the following instruction executes as a delay slot).
// ---------------------------------------------------------------------------
module decode_branch_ctrl
    import decode_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrF,
    input  logic [31:0] pcF,
    input  logic [31:0] rsDataD,
    input  logic [31:0] rtDataD,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic [4:0]  rsD,
    output logic [4:0]  rtD,
    output logic        PCSrcD,
    output logic [31:0] PCbranchD,
    output logic        hazardDetected,
    output logic        issueD
);

    dest_info_t info;
    shadow_t    ex_q, mem_q;

    logic [5:0]  op;
    logic        is_beq, is_bne, is_j, is_br;
    logic [31:0] pc_plus4, br_off, br_target, j_target;
    logic        load_use, br_hazard, taken;

    instr_dest_decode u_dec (
        .instr (instrD),
        .info  (info)
    );

    assign op     = instrD[31:26];
    assign rsD    = instrD[25:21];
    assign rtD    = instrD[20:16];
    assign is_beq = (op == OP_BEQ);
    assign is_bne = (op == OP_BNE);
    assign is_j   = (op == OP_J);
    assign is_br  = is_beq || is_bne;

    assign pc_plus4  = pcD + 32'd4;
    assign br_off    = {{14{instrD[15]}}, instrD[15:0], 2'b00};
    assign br_target = pc_plus4 + br_off;
    assign j_target  = {pc_plus4[31:28], instrD[25:0], 2'b00};

    // Shadow entries are only valid for real writes (dst != 0), so a source
    // of $0 can never match.
    assign load_use = ex_q.v && ex_q.isLoad &&
                      ((info.readsRs && rsD == ex_q.dst) ||
                       (info.readsRt && rtD == ex_q.dst));

    // Branches compare in decode, so they also wait on any ALU result still
    // in EX and on a load still in MEM.
    assign br_hazard = is_br &&
                       ((ex_q.v && (rsD == ex_q.dst || rtD == ex_q.dst)) ||
                        (mem_q.v && mem_q.isLoad &&
                         (rsD == mem_q.dst || rtD == mem_q.dst)));

    assign hazardDetected = validD && (load_use || br_hazard);
    assign issueD         = validD && !hazardDetected;

    assign taken     = is_j || (is_beq && rsDataD == rtDataD) ||
                       (is_bne && rsDataD != rtDataD);
    // Redirect suppressed while reset is asserted so fetch never sees a
    // target from state about to be cleared.
    assign PCSrcD    = !rst && issueD && taken;
    assign PCbranchD = is_j ? j_target : (is_br ? br_target : 32'd0);

    // IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            instrD <= NOP_INSTR;
            pcD    <= RESET_PC;
            validD <= 1'b0;
        end else if (hazardDetected) begin
            instrD <= instrD;
            pcD    <= pcD;
            validD <= validD;
`ifdef DELAY_SLOT_EN
        end else begin
            instrD <= instrF;
            pcD    <= pcF;
            validD <= 1'b1;
        end
`else
        end else if (PCSrcD) begin
            // Drop the wrong-path instruction fetched alongside the redirect
            instrD <= NOP_INSTR;
            pcD    <= pcF;
            validD <= 1'b0;
        end else begin
            instrD <= instrF;
            pcD    <= pcF;
            validD <= 1'b1;
        end
`endif
    end

    // EX/MEM shadow; a stalled or empty decode slot enters EX as a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            if (issueD) begin
                ex_q.v      <= info.writes;
                ex_q.dst    <= info.dst;
                ex_q.isLoad <= info.isLoad;
            end else begin
                ex_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_branch_ctrl
// Table-driven bench: each row drives one cycle of inputs and carries the
// outputs expected during that cycle. Expectations go through a queue and
// are compared against the DUT mid-cycle.
// ---------------------------------------------------------------------------
module tb_decode_branch_ctrl;

    typedef struct packed {
        logic [31:0] instrD;
        logic [31:0] pcD;
        logic        validD;
        logic        haz;
        logic        pcsrc;
        logic [31:0] pcbr;
        logic        issue;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] instrF;
        logic [31:0] pcF;
        logic [31:0] rsData;
        logic [31:0] rtData;
        exp_t        e;
    } vec_t;

    localparam logic [31:0] LW1   = 32'h8C01_0004; // lw  $1,4($0)
    localparam logic [31:0] ADD   = 32'h0021_1020; // add $2,$1,$1
    localparam logic [31:0] ADDI  = 32'h2006_0001; // addi $6,$0,1
    localparam logic [31:0] BEQ34 = 32'h1064_0003; // beq $3,$4,+3
    localparam logic [31:0] BNE34 = 32'h1464_0001; // bne $3,$4,+1
    localparam logic [31:0] LW5   = 32'h8C05_0000; // lw  $5,0($0)
    localparam logic [31:0] BEQ50 = 32'h10A0_0002; // beq $5,$0,+2
    localparam logic [31:0] JMP   = 32'h0800_0010; // j 0x10
    localparam int          NV    = 21;

`ifdef DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] instrF, pcF, rsDataD, rtDataD;
    logic [31:0] instrD, pcD, PCbranchD;
    logic        validD, PCSrcD, hazardDetected, issueD;
    logic [4:0]  rsD, rtD;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs[NV];
    exp_t sb[$];

    decode_branch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .instrF         (instrF),
        .pcF            (pcF),
        .rsDataD        (rsDataD),
        .rtDataD        (rtDataD),
        .instrD         (instrD),
        .pcD            (pcD),
        .validD         (validD),
        .rsD            (rsD),
        .rtD            (rtD),
        .PCSrcD         (PCSrcD),
        .PCbranchD      (PCbranchD),
        .hazardDetected (hazardDetected),
        .issueD         (issueD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(logic r, logic [31:0] fi, logic [31:0] fp,
                                 logic [31:0] rsd, logic [31:0] rtd,
                                 logic [31:0] ei, logic [31:0] ep, logic ev,
                                 logic eh, logic es, logic [31:0] eb, logic eiss);
        vec_t v;
        v.rst      = r;
        v.instrF   = fi;
        v.pcF      = fp;
        v.rsData   = rsd;
        v.rtData   = rtd;
        v.e.instrD = ei;
        v.e.pcD    = ep;
        v.e.validD = ev;
        v.e.haz    = eh;
        v.e.pcsrc  = es;
        v.e.pcbr   = eb;
        v.e.issue  = eiss;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] slot_i;
        exp_t        e;
        slot_i = DS ? ADDI : 32'h0;

        //                rst instrF pcF          rs rt | instrD pcD          v  haz src pcbr         iss
        // reset for two cycles, then lw loads on the first free edge
        vecs[0]  = mkv(1, LW1,   32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0, 32'h0,        0);
        vecs[1]  = mkv(0, LW1,   32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0, 32'h0,        0);
        // load-use: add stalls exactly one cycle behind lw
        vecs[2]  = mkv(0, ADD,   32'h4,        0, 0, LW1,   32'h0,        1, 0, 0, 32'h0,        1);
        vecs[3]  = mkv(0, ADDI,  32'h8,        0, 0, ADD,   32'h4,        1, 1, 0, 32'h0,        0);
        vecs[4]  = mkv(0, ADDI,  32'h8,        0, 0, ADD,   32'h4,        1, 0, 0, 32'h0,        1);
        vecs[5]  = mkv(0, BEQ34, 32'h40,       0, 0, ADDI,  32'h8,        1, 0, 0, 32'h0,        1);
        // taken beq at 0x40 -> 0x50, next slot flushed (or delay slot)
        vecs[6]  = mkv(0, ADDI,  32'h44,       7, 7, BEQ34, 32'h40,       1, 0, 1, 32'h50,       1);
        vecs[7]  = mkv(0, BNE34, 32'h50,       5, 5, slot_i, 32'h44,      DS, 0, 0, 32'h0,       DS);
        // not-taken bne, following lw loads normally
        vecs[8]  = mkv(0, LW5,   32'h54,       5, 5, BNE34, 32'h50,       1, 0, 0, 32'h58,       1);
        vecs[9]  = mkv(0, BEQ50, 32'h58,       0, 0, LW5,   32'h54,       1, 0, 0, 32'h0,        1);
        // beq after load: two stall cycles, no redirect while stalled
        vecs[10] = mkv(0, ADDI,  32'h5C,       0, 0, BEQ50, 32'h58,       1, 1, 0, 32'h64,       0);
        vecs[11] = mkv(0, ADDI,  32'h5C,       0, 0, BEQ50, 32'h58,       1, 1, 0, 32'h64,       0);
        vecs[12] = mkv(0, ADDI,  32'h60,       0, 0, BEQ50, 32'h58,       1, 0, 1, 32'h64,       1);
        vecs[13] = mkv(0, JMP,   32'hFFFF_FFFC,0, 0, slot_i, 32'h60,      DS, 0, 0, 32'h0,       DS);
        // jump with pc+4 wrapping to 0
        vecs[14] = mkv(0, ADDI,  32'h0,        0, 0, JMP,   32'hFFFF_FFFC,1, 0, 1, 32'h40,       1);
        vecs[15] = mkv(0, BEQ34, 32'h40,       7, 7, slot_i, 32'h0,       DS, 0, 0, 32'h0,       DS);
        // reset while a taken branch is in decode: no redirect emitted
        vecs[16] = mkv(1, ADD,   32'h44,       7, 7, BEQ34, 32'h40,       1, 0, 0, 32'h50,       1);
        vecs[17] = mkv(0, LW1,   32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0, 32'h0,        0);
        // reset while stalled: shadow cleared, no stall afterwards
        vecs[18] = mkv(0, ADD,   32'h4,        0, 0, LW1,   32'h0,        1, 0, 0, 32'h0,        1);
        vecs[19] = mkv(1, ADDI,  32'h8,        0, 0, ADD,   32'h4,        1, 1, 0, 32'h0,        0);
        vecs[20] = mkv(0, ADDI,  32'h8,        0, 0, 32'h0, 32'h0,        0, 0, 0, 32'h0,        0);

        rst = 1'b1; instrF = '0; pcF = '0; rsDataD = '0; rtDataD = '0;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            instrF  = vecs[i].instrF;
            pcF     = vecs[i].pcF;
            rsDataD = vecs[i].rsData;
            rtDataD = vecs[i].rtData;
            sb.push_back(vecs[i].e);
            #2;
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL row %0d scoreboard: got empty expected entry", i);
            end else begin
                e = sb.pop_front();
                chk("instrD",         i, instrD,                e.instrD);
                chk("pcD",            i, pcD,                   e.pcD);
                chk("validD",         i, {31'd0, validD},       {31'd0, e.validD});
                chk("rsD",            i, {27'd0, rsD},          {27'd0, e.instrD[25:21]});
                chk("rtD",            i, {27'd0, rtD},          {27'd0, e.instrD[20:16]});
                chk("hazardDetected", i, {31'd0, hazardDetected}, {31'd0, e.haz});
                chk("PCSrcD",         i, {31'd0, PCSrcD},       {31'd0, e.pcsrc});
                chk("PCbranchD",      i, PCbranchD,             e.pcbr);
                chk("issueD",         i, {31'd0, issueD},       {31'd0, e.issue});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
